// File: rtl/tcp_tx_framer.sv
// tcp_tx_framer: buffers 32-bit readout words and sends them to SiTCP as byte frames.
// Define TX_FRAME_CHECKSUM_EN to append an XOR-of-payload trailer byte to every frame.
module tcp_tx_framer #(
    parameter int DEPTH     = 256,
    parameter int MAX_WORDS = 64,
    parameter int TIMEOUT   = 4000
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST,
    input  logic        WRITE,
    input  logic [31:0] DATA_IN,
    output logic        READY_OUT,
    input  logic        TCP_TX_FULL,
    output logic        TCP_TX_WR,
    output logic [7:0]  TCP_TX_DATA,
    output logic [15:0] FRAME_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [31:0]   MAXW     = 32'(MAX_WORDS);
    localparam logic [31:0]   TMO      = 32'(TIMEOUT);

`ifdef TX_FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HDR, PAY, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
`endif

    state_t state, state_nxt;

    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [31:0]      count_w;
    logic [31:0]      timer;
    logic [1:0]       byte_idx;
    logic [15:0]      word_cnt, n_words, n_next;
    logic [3:0][7:0]  cur;
    logic             push, pop, start, frame_done, last_word;
`ifdef TX_FRAME_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign count_w   = 32'(count);
    assign READY_OUT = (count != FULL_CNT);
    assign push      = WRITE && READY_OUT;
    assign cur       = mem[rd_ptr];
    assign n_next    = (count_w >= MAXW) ? MAXW[15:0] : count_w[15:0];
    assign last_word = (word_cnt == n_words - 16'd1);
    assign TCP_TX_WR = (state != IDLE) && !TCP_TX_FULL;

    always_ff @(posedge BUS_CLK) begin
        if (push)
            mem[wr_ptr] <= DATA_IN;
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        TCP_TX_DATA = 8'h00;
        start       = 1'b0;
        pop         = 1'b0;
        frame_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (count_w >= MAXW || (count != '0 && timer == TMO)) begin
                    start     = 1'b1;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                unique case (byte_idx)
                    2'd0: TCP_TX_DATA = 8'hA5;
                    2'd1: TCP_TX_DATA = 8'h5A;
                    2'd2: TCP_TX_DATA = n_words[15:8];
                    2'd3: TCP_TX_DATA = n_words[7:0];
                endcase
                if (TCP_TX_WR && byte_idx == 2'd3)
                    state_nxt = PAY;
            end
            PAY: begin
                TCP_TX_DATA = cur[byte_idx];
                if (TCP_TX_WR && byte_idx == 2'd3) begin
                    pop = 1'b1;
                    if (last_word) begin
`ifdef TX_FRAME_CHECKSUM_EN
                        state_nxt = CHK;
`else
                        state_nxt  = IDLE;
                        frame_done = 1'b1;
`endif
                    end
                end
            end
`ifdef TX_FRAME_CHECKSUM_EN
            CHK: begin
                TCP_TX_DATA = csum;
                if (TCP_TX_WR) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            timer     <= '0;
            byte_idx  <= '0;
            word_cnt  <= '0;
            n_words   <= '0;
            FRAME_CNT <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // timer only runs while a partial frame waits in IDLE
            if (start || count == '0)
                timer <= '0;
            else if (state == IDLE && count_w < MAXW && timer != TMO)
                timer <= timer + 32'd1;
            if (start) begin
                byte_idx <= '0;
                word_cnt <= '0;
                n_words  <= n_next;
            end else begin
                if (TCP_TX_WR)
                    byte_idx <= byte_idx + 2'd1;
                if (pop)
                    word_cnt <= word_cnt + 16'd1;
            end
            if (frame_done)
                FRAME_CNT <= FRAME_CNT + 16'd1;
        end
    end

`ifdef TX_FRAME_CHECKSUM_EN
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST)
            csum <= '0;
        else if (start)
            csum <= '0;
        else if (state == PAY && TCP_TX_WR)
            csum <= csum ^ TCP_TX_DATA;
    end
`endif

endmodule

// File: tb/tb_tcp_tx_framer.sv
// tb_tcp_tx_framer: directed frames checked against a byte-queue model every cycle,
// plus literal byte/timing expectations per scenario.
module tb_tcp_tx_framer;

    localparam int DEPTH = 8;
    localparam int MAXW  = 4;
    localparam int TMO   = 10;
`ifdef TX_FRAME_CHECKSUM_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write = 1'b0;
    logic [31:0] din = '0;
    logic        full = 1'b0;
    logic        ready;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic [15:0] fcnt;

    tcp_tx_framer #(.DEPTH(DEPTH), .MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
        .BUS_CLK(clk),
        .BUS_RST(rst),
        .WRITE(write),
        .DATA_IN(din),
        .READY_OUT(ready),
        .TCP_TX_FULL(full),
        .TCP_TX_WR(tx_wr),
        .TCP_TX_DATA(tx_data),
        .FRAME_CNT(fcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         last;
        bit         wend;
    } ent_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          occ = 0;
    int          frames = 0;
    int          wr_cyc = 0;
    ent_t        exp_q[$];
    ent_t        e;
    logic [31:0] acc[$];
    logic [7:0]  log_b[$];
    int          log_c[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // model: queue of bytes that must appear, words held, frames finished
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc.delete();
            occ = 0;
            frames = 0;
            chk("rst_wr", 32'(tx_wr), 0);
        end else begin
            chk("frame_cnt", 32'(fcnt), frames);
            chk("ready", 32'(ready), 32'(occ != DEPTH));
            if (full)
                chk("stall_wr", 32'(tx_wr), 0);
            if (write && occ != DEPTH) begin
                acc.push_back(din);
                occ++;
                wr_cyc = cyc;
            end
            if (tx_wr) begin
                log_b.push_back(tx_data);
                log_c.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_byte: got %h want no byte (cycle %0d)", tx_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", 32'(tx_data), 32'(e.b));
                    if (e.last) frames++;
                    if (e.wend) occ--;
                end
            end
        end
    end

    task automatic expect_frame(input int n);
        logic [31:0] w;
        logic [7:0]  b;
        logic [7:0]  x;
        x = 8'h00;
        chk("frame_words", 32'(acc.size() >= n), 1);
        exp_q.push_back('{8'hA5, 1'b0, 1'b0});
        exp_q.push_back('{8'h5A, 1'b0, 1'b0});
        exp_q.push_back('{8'(n >> 8), 1'b0, 1'b0});
        exp_q.push_back('{8'(n), 1'b0, 1'b0});
        for (int i = 0; i < n; i++) begin
            if (acc.size() == 0) break;
            w = acc.pop_front();
            for (int k = 0; k < 4; k++) begin
                b = 8'(w >> (8 * k));
                x ^= b;
                exp_q.push_back('{b, (i == n - 1 && k == 3 && TRL == 0), (k == 3)});
            end
        end
        if (TRL == 1)
            exp_q.push_back('{x, 1'b1, 1'b0});
    endtask

    task automatic put(input logic [31:0] w);
        @(posedge clk); #1;
        write = 1'b1;
        din = w;
    endtask

    task automatic put_end();
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic wait_bytes(input int n);
        int t = 0;
        while (log_b.size() < n && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        chk("wait_bytes", 32'(log_b.size() >= n), 1);
    endtask

    task automatic stall(input int n);
        @(posedge clk); #1;
        full = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        full = 1'b0;
    endtask

    logic [7:0] h1[4]  = '{8'hA5, 8'h5A, 8'h00, 8'h04};
    logic [7:0] t2[8]  = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] t3[12] = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h11, 8'h22,
                           8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(ready), 1);
        chk("reset_wr", 32'(tx_wr), 0);
        chk("reset_data", 32'(tx_data), 0);
        chk("reset_fcnt", 32'(fcnt), 0);
        rst = 1'b0;

        // full frame on MAX_WORDS
        log_b.delete(); log_c.delete();
        put(32'h03020100); put(32'h07060504); put(32'h0B0A0908); put(32'h0F0E0D0C);
        put_end();
        expect_frame(4);
        drain();
        chk("t1_len", log_b.size(), 20 + TRL);
        for (int i = 0; i < 20; i++)
            chk("t1_byte", 32'(log_b[i]), (i < 4) ? 32'(h1[i]) : 32'(i - 4));
        chk("t1_latency", log_c[0], wr_cyc + 2);
        chk("t1_burst", log_c[19] - log_c[0], 19);
        chk("t1_fcnt", 32'(fcnt), 1);

        // single word flushed by timeout
        log_b.delete(); log_c.delete();
        put(32'hDEADBEEF);
        put_end();
        expect_frame(1);
        drain();
        chk("t2_len", log_b.size(), 8 + TRL);
        for (int i = 0; i < 8; i++)
            chk("t2_byte", 32'(log_b[i]), 32'(t2[i]));
        chk("t2_timeout", log_c[0], wr_cyc + 12);
        chk("t2_fcnt", 32'(fcnt), 2);

        // stalls in header and payload
        log_b.delete(); log_c.delete();
        put(32'h44332211); put(32'h88776655);
        put_end();
        expect_frame(2);
        wait_bytes(2);
        stall(5);
        wait_bytes(7);
        stall(3);
        drain();
        chk("t3_len", log_b.size(), 12 + TRL);
        for (int i = 0; i < 12; i++)
            chk("t3_byte", 32'(log_b[i]), 32'(t3[i]));
        chk("t3_gap_hdr", log_c[2] - log_c[1], 6);
        chk("t3_gap_pay", log_c[7] - log_c[6], 4);
        chk("t3_fcnt", 32'(fcnt), 3);

        // fill buffer while sink is full
        log_b.delete(); log_c.delete();
        full = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            write = 1'b1;
            din = 32'h1000_0000 + 32'(k);
            @(negedge clk);
            if (ready) k++;
        end
        @(posedge clk); #1;
        write = 1'b0;
        chk("t4_accepted", k, 8);
        chk("t4_ready_full", 32'(ready), 0);
        expect_frame(4);
        expect_frame(4);
        @(posedge clk); #1;
        full = 1'b0;
        drain();
        chk("t4_ready_after", 32'(ready), 1);
        chk("t4_len", log_b.size(), 40 + 2 * TRL);
        chk("t4_w0_b3", 32'(log_b[7]), 32'h10);
        chk("t4_f2_hdr", 32'(log_b[20 + TRL]), 32'hA5);
        chk("t4_w7_b0", 32'(log_b[36 + TRL]), 32'h07);
        chk("t4_fcnt", 32'(fcnt), 5);

        // reset in the middle of a payload
        log_b.delete(); log_c.delete();
        put(32'hA3A2A1A0); put(32'hB3B2B1B0); put(32'hC3C2C1C0); put(32'hD3D2D1D0);
        put_end();
        expect_frame(4);
        wait_bytes(6);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_wr", 32'(tx_wr), 0);
        chk("t5_rst_ready", 32'(ready), 1);
        chk("t5_rst_fcnt", 32'(fcnt), 0);
        chk("t5_rst_data", 32'(tx_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        log_b.delete(); log_c.delete();
        put(32'h11111111); put(32'h22222222); put(32'h33333333); put(32'h44444444);
        put_end();
        expect_frame(4);
        wait_bytes(1);
        chk("t5_first", 32'(log_b[0]), 32'hA5);
        drain();
        chk("t5_fcnt", 32'(fcnt), 1);

`ifdef TX_FRAME_CHECKSUM_EN
        log_b.delete(); log_c.delete();
        put(32'h01020304);
        put_end();
        expect_frame(1);
        drain();
        chk("t6_len", log_b.size(), 9);
        chk("t6_trailer", 32'(log_b[8]), 32'h04);
        chk("t6_fcnt", 32'(fcnt), 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want test end");
        $fatal(1);
    end

endmodule

// File: doc/tcp_tx_framer.md
Name: tcp_tx_framer

Overview:
- Sits between the 32-bit readout data source (single FE channel or arbiter output) and the SiTCP TCP TX byte interface.
- Replaces the bare 32-to-8 conversion stage.
- Buffers 32-bit words and emits them as framed byte bursts: 4-byte header, then payload bytes.
- A frame is flushed when enough words are buffered or when data has waited too long.

Parameters:
- DEPTH, 256: input buffer depth in 32-bit words; power of 2, >= MAX_WORDS.
- MAX_WORDS, 64: maximum payload words per frame; 1..65535.
- TIMEOUT, 4000: BUS_CLK cycles a partial frame may wait before a forced flush; >= 1.

Ports:
- BUS_CLK  in  1  sole clock.
- BUS_RST  in  1  asynchronous active-high reset.
- WRITE  in  1  data word valid from upstream.
- DATA_IN  in  32  data word.
- READY_OUT  out  1  buffer can accept a word (= not full).
- TCP_TX_FULL  in  1  SiTCP TX almost-full.
- TCP_TX_WR  out  1  byte strobe to SiTCP.
- TCP_TX_DATA  out  8  byte to SiTCP.
- FRAME_CNT  out  16  frames completed, wraps 0xFFFF->0.

Behaviour:
- Clocking and reset: one clock, BUS_CLK. Reset BUS_RST is asynchronous, active-high.
- Reset values:
  - buffer empty
  - READY_OUT=1
  - TCP_TX_WR=0
  - TCP_TX_DATA=0
  - FRAME_CNT=0
  - timer=0
  - state=IDLE
- Input handshake:
  - Word written when WRITE && READY_OUT.
  - READY_OUT=0 when buffer holds DEPTH words.
  - WRITE while full is ignored; upstream must hold the word.
  - A buffer read in the same cycle does not admit a write at full; READY_OUT is evaluated on registered count.
- Occupancy: count width clog2(DEPTH)+1. Simultaneous write and read leaves count unchanged.
- Timer:
  - Increments each cycle in IDLE while 0 < count < MAX_WORDS.
  - Cleared when count==0 or a frame starts.
  - Saturates at TIMEOUT.
- State machine: IDLE -> HDR -> PAY -> IDLE.
  - IDLE -> HDR when count >= MAX_WORDS, or (count > 0 and timer == TIMEOUT).
  - On entering HDR, latch N = min(count, MAX_WORDS), 16 bits. Words arriving later belong to later frames.
  - HDR emits 4 bytes in order: 0xA5, 0x5A, N[15:8], N[7:0].
  - PAY emits N words, each as 4 bytes little-endian: DATA[7:0] first, DATA[31:24] last. A word is popped from the buffer when its 4th byte is accepted.
  - After the last payload byte, FRAME_CNT increments and the state returns to IDLE.
  - A new frame may start on the cycle after returning to IDLE.
- Output handshake:
  - TCP_TX_WR = (state in HDR/PAY) && !TCP_TX_FULL; combinational on TCP_TX_FULL.
  - TCP_TX_DATA is valid whenever TCP_TX_WR=1.
  - The byte pointer advances only when TCP_TX_WR=1.
  - TCP_TX_FULL stalls the frame at any byte, including the header, with no byte loss or duplication.
  - Throughput: 1 byte/cycle when not stalled.
- Latency: first word into an empty buffer with MAX_WORDS=1 gives the first header byte 2 cycles after the write cycle.
- Reset mid-frame: frame aborted, buffer flushed, outputs return to reset values immediately.
- FRAME_CNT wraps silently.

Optional Feature:
- Macro: TX_FRAME_CHECKSUM_EN.
- Defined:
  - A state CHK follows PAY.
  - CHK emits one trailer byte = XOR of all 4*N payload bytes; header bytes excluded.
  - CHK obeys the same TCP_TX_FULL stall rule.
  - FRAME_CNT increments after the trailer byte.
  - N in the header still counts payload words only.
- Undefined: no CHK state, no trailer; frame ends after the last payload byte.

Test Plan:
- MAX_WORDS=4, TCP_TX_FULL=0; write 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C -> bytes A5 5A 00 04 then 00 01 02 ... 0F on 20 consecutive TCP_TX_WR cycles; FRAME_CNT=1.
- MAX_WORDS=4, TIMEOUT=10; write one word 0xDEADBEEF -> no output until timer reaches 10, then A5 5A 00 01 EF BE AD DE; FRAME_CNT=1.
- Frame of 2 words; assert TCP_TX_FULL for 5 cycles after header byte 2 and again mid-payload -> TCP_TX_WR=0 during stalls, byte stream identical to the unstalled case, no drops or duplicates.
- DEPTH=8, TCP_TX_FULL held 1, WRITE held 1 for 12 cycles -> READY_OUT falls after 8 accepted words; release TCP_TX_FULL -> all 8 words emitted in order, then READY_OUT=1.
- Assert BUS_RST during payload byte 3 of a frame -> TCP_TX_WR=0 immediately, READY_OUT=1, FRAME_CNT=0; a subsequent frame starts with header 0xA5.
- With TX_FRAME_CHECKSUM_EN, one word 0x01020304 -> trailer byte 0x04 (04^03^02^01) follows the payload; FRAME_CNT increments after the trailer.
